uart_rx: RTL
============

# uart_rx

Serial receive front end for the pipeline CPU's UART peripheral: turns the asynchronous `din` line into bytes for the CPU's memory-mapped UART receive register. 8N1 framing (optional even parity), 16× oversampling, one-byte holding register with valid/ready handshake, framing/overrun error pulses. Default rate is 9600 baud from the 100 MHz system clock, so one bit is 104160 ns.

## Interface
- `CLK_FREQ`, 100000000, system clock in Hz
- `BAUD`, 9600, line rate
- `OS_DIV`, CLK_FREQ/(BAUD*16) = 651, clocks per oversample tick (integer division, truncated)

- `clk`  in  1  system clock; one clock, everything on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `din`  in  1  async serial input, idle high
- `rx_data`  out  8  received byte, LSB first on line
- `rx_valid`  out  1  `rx_data` holds an unread byte
- `rx_ready`  in  1  consumer takes byte when `rx_valid & rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0
- `overrun`  out  1  one-cycle pulse: byte completed while holding register full
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without macro)

## Operation
- `din` passes a 2-flop synchronizer; both flops reset to 1.
- Tick counter counts 0..OS_DIV-1, emits `tick` on wrap. It is cleared on start detection so bit timing is phase-locked to the falling edge.
- Sample counter (4 bit, 0..15) advances per tick. The bit value is the majority of synchronized samples at counts 7, 8 and 9. Bit decision is made at count 9.
- FSM states:
  - IDLE: waits for synchronized line = 0, then clears counters and goes to START.
  - START: at the mid-bit decision, a majority of 1 is a false start and returns to IDLE with no error. A majority of 0 goes to DATA with bit index 0.
  - DATA: shifts the decided bit into shift[7] (right shift) each bit. After index 7 goes to STOP, or to PARITY when the macro is defined.
  - PARITY: compares the decided bit with the even parity of the 8 data bits, latches the mismatch, then goes to STOP.
  - STOP: at the decision, a 1 is a good frame: deliver the byte (see below) and go to IDLE immediately. This is mid-stop, so back-to-back frames are not missed. A 0 pulses `frame_err`, discards the byte and goes to BREAK.
  - BREAK: waits for synchronized line = 1, then goes to IDLE.
- Delivery:
  - If `rx_valid`=0, or `rx_valid & rx_ready` in the same cycle: load `rx_data`, set `rx_valid`=1.
  - Otherwise: pulse `overrun`, drop the new byte, keep the old one.
  - A parity mismatch still delivers the byte and pulses `parity_err` in the same cycle as the load.
- `rx_valid` clears the cycle after `rx_valid & rx_ready`, unless a new byte loads in that same cycle.
- `rx_ready` while `rx_valid`=0 has no effect.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, all error pulses 0.
  - FSM in IDLE, counters 0.
- Reset mid-frame aborts the frame. The next falling edge seen after reset is treated as a start bit.
- Latency: `rx_valid` rises 1 cycle after the stop-bit decision cycle. That is about 2 (sync) + 9.5625 bit periods after the `din` falling edge, ≈ 99603 cycles at default settings.
- Error pulses are exactly 1 cycle wide and coincide with the FSM decision cycle +1.
- Tolerated baud mismatch is ±4% (mid-bit sampling over 10 bits).

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is start + 8 data + even parity + stop (11 bits), and the PARITY state and `parity_err` are live.
  - Undefined: 10-bit 8N1 frame, no PARITY state, `parity_err` tied 0.

## Test plan
- Reset, then send 0x55 8N1 at 104160 ns/bit, `rx_ready`=1 → `rx_valid` pulses 1 cycle with `rx_data`=0x55, no errors.
- 20 µs low glitch on idle `din` → no state change past START, `rx_valid`=0, no errors.
- Send 0xA3 then 0x3C back-to-back with `rx_ready`=0 → `rx_data`=0xA3, `rx_valid` held, `overrun` pulses once at the second stop bit; then `rx_ready`=1 → `rx_valid` clears.
- Send 0x81 with stop bit forced 0, line held low 3 bit times, then idle and send 0x7E → `frame_err` pulse, no delivery; then 0x7E is delivered cleanly.
- Assert `reset` during data bit 4 of 0xF0, release, send 0x0F → only 0x0F is delivered.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → delivered, no error; with parity bit 0 → delivered, `parity_err` pulses in the load cycle.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with one-byte holding register and error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit to the frame and enable parity_err.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OS_DIV   = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [3:0]      samp_cnt_q;
    logic            maj_a_q;
    logic            maj_b_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_q;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q;
    logic            parity_err_q;
`endif

    logic rx_s;
    logic tick_c;
    logic decide_c;
    logic bit_c;
    logic take_c;
    logic can_load_c;

    assign rx_s       = sync_q[1];
    assign tick_c     = (tick_cnt_q == TW'(OS_DIV - 1));
    // Samples taken as the count enters 7 and 8; decision as it enters 9.
    assign decide_c   = tick_c && (samp_cnt_q == 4'd8);
    assign bit_c      = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
    assign take_c     = rx_valid_q & rx_ready;
    assign can_load_c = ~rx_valid_q | rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            tick_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            maj_a_q      <= 1'b1;
            maj_b_q      <= 1'b1;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], din};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (take_c) begin
                rx_valid_q <= 1'b0;
            end

            // Counters restart on the start edge so sampling is phase-locked to it.
            if (state_q == S_IDLE && !rx_s) begin
                tick_cnt_q <= '0;
                samp_cnt_q <= '0;
            end else if (tick_c) begin
                tick_cnt_q <= '0;
                samp_cnt_q <= samp_cnt_q + 4'd1;
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end

            if (tick_c && samp_cnt_q == 4'd6) maj_a_q <= rx_s;
            if (tick_c && samp_cnt_q == 4'd7) maj_b_q <= rx_s;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) state_q <= S_START;
                end
                S_START: begin
                    if (decide_c) begin
                        if (bit_c) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (decide_c) begin
                        shift_q   <= {bit_c, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (decide_c) begin
                        par_bad_q <= (bit_c != ^shift_q);
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Deciding mid-stop leaves half a bit to catch a back-to-back start.
                    if (decide_c) begin
                        if (bit_c) begin
                            state_q <= S_IDLE;
                            if (can_load_c) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= par_bad_q;
`endif
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
